// File: rtl/wdt_ctrl.sv
// wdt_ctrl: bus register front-end for a watchdog timer. Decodes single-beat
// reads/writes into enable, stretched kick pulse and timeout count, and turns
// the watchdog's asynchronous timeout line into a sticky status bit and a
// maskable interrupt.
module wdt_ctrl #(
  parameter int LIVE_PULSE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        wto_in,
  output logic        wdt_irq
);

  localparam logic [7:0] LIVE_LOAD = 8'(LIVE_PULSE);
  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_KICK    = 4'h4;
  localparam logic [3:0] A_TOCNT   = 4'h8;
  localparam logic [3:0] A_STATUS  = 4'hC;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        hit;
  logic        bad_wr;
  logic [31:0] rd_val;
  logic        wr_ctrl, wr_kick, wr_tocnt, wr_status;

  logic        wden_q;
  logic [7:0]  live_cnt_q;
  logic [31:0] wtocnt_q;
  logic        irq_en_q;
  logic        wto_sticky_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // timeout synchroniser chain: meta flop, synchronised level, edge-detect delay
  logic        wto_meta_p0, wto_sync_p1, wto_dly_p2;
  logic        wto_rise;

  // handshake state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // handshake next state and ready/valid: one request outstanding at a time
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // address decode: read mux from pre-write state, and write-rejection rule
  always_comb begin
    hit    = 1'b1;
    bad_wr = 1'b0;
    rd_val = '0;
    case (req_addr)
      A_CTRL:   rd_val = {31'b0, wden_q};
      A_KICK:   rd_val = {31'b0, WDLIVE};
      A_TOCNT: begin
        rd_val = wtocnt_q;
        bad_wr = req_write && wden_q;
      end
      A_STATUS: rd_val = {23'b0, irq_en_q, 6'b0, wto_sync_p1, wto_sticky_q};
      default:  hit = 1'b0;
    endcase
  end

  assign wr_ctrl   = accept && req_write && (req_addr == A_CTRL);
  assign wr_kick   = accept && req_write && (req_addr == A_KICK) && req_wdata[0];
  assign wr_tocnt  = accept && req_write && (req_addr == A_TOCNT) && !wden_q;
  assign wr_status = accept && req_write && (req_addr == A_STATUS);

  // control registers, kick counter and sticky timeout status
  always_ff @(posedge clk) begin
    if (rst) begin
      wden_q       <= 1'b0;
      live_cnt_q   <= '0;
      wtocnt_q     <= '0;
      irq_en_q     <= 1'b0;
      wto_sticky_q <= 1'b0;
    end else begin
      if (wr_ctrl)  wden_q   <= req_wdata[0];
      if (wr_tocnt) wtocnt_q <= req_wdata;
      if (wr_status) irq_en_q <= req_wdata[8];
      // a reload during an active pulse extends it without a gap
      if (wr_kick)                live_cnt_q <= LIVE_LOAD;
      else if (live_cnt_q != '0)  live_cnt_q <= live_cnt_q - 8'd1;
      // a new edge beats a simultaneous write-1-to-clear
      if (wto_rise)                        wto_sticky_q <= 1'b1;
      else if (wr_status && req_wdata[0])  wto_sticky_q <= 1'b0;
    end
  end

  // response capture at accept; held stable while the response waits
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      resp_rdata_q <= req_write ? 32'b0 : rd_val;
      resp_err_q   <= !hit || bad_wr;
    end
  end

  // two-flop synchroniser for wto_in plus a delay flop for rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      wto_meta_p0 <= 1'b0;
      wto_sync_p1 <= 1'b0;
      wto_dly_p2  <= 1'b0;
    end else begin
      wto_meta_p0 <= wto_in;
      wto_sync_p1 <= wto_meta_p0;
      wto_dly_p2  <= wto_sync_p1;
    end
  end

  assign wto_rise   = wto_sync_p1 && !wto_dly_p2;
  assign WDEN       = wden_q;
  assign WDLIVE     = (live_cnt_q != '0);
  assign WTOCNT     = wtocnt_q;
  assign wdt_irq    = wto_sticky_q && irq_en_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed bench for wdt_ctrl with LIVE_PULSE=4. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_wdt_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        WDEN;
  logic        WDLIVE;
  logic [31:0] WTOCNT;
  logic        wto_in;
  logic        wdt_irq;

  int total = 0;
  int bad   = 0;
  int live_hi = 0;
  int live_rise = 0;
  logic live_prev = 1'b0;

  logic [31:0] rd;
  logic        er;

  wdt_ctrl #(.LIVE_PULSE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .WDEN       (WDEN),
    .WDLIVE     (WDLIVE),
    .WTOCNT     (WTOCNT),
    .wto_in     (wto_in),
    .wdt_irq    (wdt_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WDLIVE high-cycle and rising-edge counter
  always @(negedge clk) begin
    if (WDLIVE && !live_prev) live_rise++;
    if (WDLIVE) live_hi++;
    live_prev = WDLIVE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one bus transaction; starts and ends on a falling edge, resp_ready held 1
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rdat, output logic err);
    int n;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (resp_valid !== 1'b1) chk("resp_valid_after_accept", {31'b0, resp_valid}, 32'd1);
    rdat = resp_rdata;
    err  = resp_err;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b1; wto_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_wdlive", {31'b0, WDLIVE}, 32'd0);
    chk("rst_irq", {31'b0, wdt_irq}, 32'd0);
    chk("rst_wden", {31'b0, WDEN}, 32'd0);
    chk("rst_wtocnt", WTOCNT, 32'd0);
    xfer(1'b0, 4'h0, 0, rd, er); chk("rst_rd_ctrl", rd, 0);   chk("rst_rd_ctrl_err", {31'b0, er}, 0);
    xfer(1'b0, 4'h4, 0, rd, er); chk("rst_rd_kick", rd, 0);   chk("rst_rd_kick_err", {31'b0, er}, 0);
    xfer(1'b0, 4'h8, 0, rd, er); chk("rst_rd_tocnt", rd, 0);  chk("rst_rd_tocnt_err", {31'b0, er}, 0);
    xfer(1'b0, 4'hC, 0, rd, er); chk("rst_rd_status", rd, 0); chk("rst_rd_status_err", {31'b0, er}, 0);

    // TOCNT / CTRL, and the locked TOCNT while enabled
    xfer(1'b1, 4'h8, 32'h0000_1000, rd, er); chk("tocnt_wr_err", {31'b0, er}, 0);
    xfer(1'b1, 4'h0, 32'h1, rd, er);         chk("ctrl_wr_err", {31'b0, er}, 0);
    xfer(1'b0, 4'h8, 0, rd, er);             chk("tocnt_rd", rd, 32'h1000);
    chk("wtocnt_out", WTOCNT, 32'h1000);
    chk("wden_out", {31'b0, WDEN}, 32'd1);
    xfer(1'b1, 4'h8, 32'h20, rd, er);        chk("tocnt_locked_err", {31'b0, er}, 32'd1);
    chk("tocnt_locked_rdata", rd, 0);
    xfer(1'b0, 4'h8, 0, rd, er);             chk("tocnt_locked_rd", rd, 32'h1000);
    chk("tocnt_locked_out", WTOCNT, 32'h1000);
    xfer(1'b0, 4'h0, 0, rd, er);             chk("ctrl_rd", rd, 32'h1);

    // single kick: 4 contiguous high cycles
    live_hi = 0; live_rise = 0;
    xfer(1'b1, 4'h4, 32'h1, rd, er);
    repeat (8) @(negedge clk);
    chk("kick1_len", live_hi, 4);
    chk("kick1_rises", live_rise, 1);

    // second kick 2 cycles into the pulse: 6 contiguous cycles
    live_hi = 0; live_rise = 0;
    xfer(1'b1, 4'h4, 32'h1, rd, er);
    xfer(1'b1, 4'h4, 32'h1, rd, er);
    repeat (10) @(negedge clk);
    chk("kick2_len", live_hi, 6);
    chk("kick2_rises", live_rise, 1);

    // kick write with bit0=0: no pulse
    live_hi = 0; live_rise = 0;
    xfer(1'b1, 4'h4, 32'h2, rd, er);
    repeat (8) @(negedge clk);
    chk("kick0_len", live_hi, 0);

    // KICK read during an active pulse
    xfer(1'b1, 4'h4, 32'h1, rd, er);
    xfer(1'b0, 4'h4, 0, rd, er);             chk("kick_rd_active", rd, 32'h1);
    repeat (8) @(negedge clk);

    // response back-pressure with a second request waiting
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8; req_wdata = '0;
    @(negedge clk);
    req_addr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'h1000);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hold_back_idle", {31'b0, req_ready}, 32'd1);
    chk("hold_resp_drop", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_next_valid", {31'b0, resp_valid}, 32'd1);
    chk("hold_next_rdata", resp_rdata, 32'h1);
    @(negedge clk);

    // timeout with irq_en=1
    xfer(1'b1, 4'hC, 32'h100, rd, er);
    wto_in = 1'b1;
    @(negedge clk); chk("wto_irq_p1", {31'b0, wdt_irq}, 0);
    @(negedge clk); chk("wto_irq_p2", {31'b0, wdt_irq}, 0);
    @(negedge clk); chk("wto_irq_p3", {31'b0, wdt_irq}, 32'd1);
    repeat (7) @(negedge clk);
    wto_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("wto_irq_stays", {31'b0, wdt_irq}, 32'd1);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("wto_status", rd, 32'h101);
    xfer(1'b1, 4'hC, 32'h101, rd, er);       chk("w1c_irq", {31'b0, wdt_irq}, 0);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("w1c_status", rd, 32'h100);

    // rising edge coincides with the W1C: set wins
    wto_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    xfer(1'b1, 4'hC, 32'h101, rd, er);
    chk("coinc_irq", {31'b0, wdt_irq}, 32'd1);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("coinc_status", rd, 32'h103);
    // held high: cleared bit does not set again
    xfer(1'b1, 4'hC, 32'h101, rd, er);
    repeat (3) @(negedge clk);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("held_status", rd, 32'h102);
    chk("held_irq", {31'b0, wdt_irq}, 0);
    wto_in = 1'b0;
    repeat (4) @(negedge clk);

    // timeout with irq_en=0
    xfer(1'b1, 4'hC, 32'h0, rd, er);
    wto_in = 1'b1;
    repeat (3) @(negedge clk);
    wto_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("noirq_irq", {31'b0, wdt_irq}, 0);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("noirq_status", rd, 32'h001);
    xfer(1'b1, 4'h0, 32'h0, rd, er);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("wden_clr_sticky", rd, 32'h001);
    xfer(1'b1, 4'hC, 32'h100, rd, er);       chk("irq_en_raise", {31'b0, wdt_irq}, 32'd1);

    // unmapped offsets and unlocked TOCNT
    xfer(1'b0, 4'h6, 0, rd, er);             chk("unmap_rd_err", {31'b0, er}, 32'd1);
    chk("unmap_rd_data", rd, 0);
    xfer(1'b1, 4'h6, 32'hFFFF_FFFF, rd, er); chk("unmap_wr_err", {31'b0, er}, 32'd1);
    xfer(1'b0, 4'h0, 0, rd, er);             chk("unmap_ctrl_same", rd, 0);
    xfer(1'b1, 4'h8, 32'h20, rd, er);        chk("tocnt_unlocked_err", {31'b0, er}, 0);
    chk("tocnt_unlocked_out", WTOCNT, 32'h20);

    // reset while a response is pending
    xfer(1'b1, 4'h4, 32'h1, rd, er);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hC;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pend_valid", {31'b0, resp_valid}, 32'd1);
    chk("pend_rdata", resp_rdata, 32'h101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    chk("mrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mrst_resp_valid", {31'b0, resp_valid}, 0);
    chk("mrst_rdata", resp_rdata, 0);
    chk("mrst_err", {31'b0, resp_err}, 0);
    chk("mrst_wdlive", {31'b0, WDLIVE}, 0);
    chk("mrst_irq", {31'b0, wdt_irq}, 0);
    chk("mrst_wtocnt", WTOCNT, 0);
    xfer(1'b0, 4'hC, 0, rd, er);             chk("mrst_status", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
